// File: rtl/program_loader.sv
// program_loader: writer side of the program memory.
// Receives a byte stream of 16-bit instructions (high byte first) followed by
// an XOR checksum byte, writes each instruction into program memory, and keeps
// the CPU core held in reset until a load completes with a good checksum.
module program_loader #(
   parameter int DataWidth = 8,
   parameter int IRWidth   = 16,   // must equal 2*DataWidth
   parameter int PC_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 res_n,
   input  logic                 start,
   input  logic [PC_WIDTH-1:0]  len,
   input  logic                 abort,
   input  logic [DataWidth-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 mem_wr_en,
   output logic [PC_WIDTH-1:0]  mem_wr_adr,
   output logic [IRWidth-1:0]   mem_wr_data,
   output logic                 cpu_hold,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HI,
      S_LO,
      S_WR,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [PC_WIDTH-1:0] AdrOne = PC_WIDTH'(1);

   state_t                r_state;
   logic [PC_WIDTH-1:0]   r_len;
   logic [DataWidth-1:0]  r_chk;
   logic [DataWidth-1:0]  r_hi;
   logic [PC_WIDTH-1:0]   r_adr;
   logic [IRWidth-1:0]    r_data;
   logic                  r_in_ready;
   logic                  r_wr_en;
   logic                  r_cpu_hold;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;

   state_t                w_state_next;
   logic [PC_WIDTH-1:0]   w_len_next;
   logic [DataWidth-1:0]  w_chk_next;
   logic [DataWidth-1:0]  w_hi_next;
   logic [PC_WIDTH-1:0]   w_adr_next;
   logic [IRWidth-1:0]    w_data_next;
   logic                  w_in_ready_next;
   logic                  w_wr_en_next;
   logic                  w_cpu_hold_next;
   logic                  w_busy_next;
   logic                  w_done_next;
   logic                  w_err_next;
   logic                  w_xfer;
   logic                  w_last;

   // A byte moves only when the loader advertised readiness this cycle.
   assign w_xfer = in_valid & r_in_ready;
   // Address equals the instruction index, so the last one sits at len-1
   // (len=0 wraps to 0xFF, i.e. a full 256-word load).
   assign w_last = (r_adr == (r_len - AdrOne));

   // Next-state, datapath and output decode; outputs are derived from the
   // next state so that they come straight out of flops.
   always_comb begin
      w_state_next = r_state;
      w_len_next   = r_len;
      w_chk_next   = r_chk;
      w_hi_next    = r_hi;
      w_adr_next   = r_adr;
      w_data_next  = r_data;

      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               w_state_next = S_HI;
               w_len_next   = len;
               w_chk_next   = '0;
               w_adr_next   = '0;
            end
         end
         S_HI: begin
            if (abort) begin
               w_state_next = S_ERR;
            end else if (w_xfer) begin
               w_hi_next    = in_data;
               w_chk_next   = r_chk ^ in_data;
               w_state_next = S_LO;
            end
         end
         S_LO: begin
            if (abort) begin
               w_state_next = S_ERR;
            end else if (w_xfer) begin
               w_data_next  = {r_hi, in_data};
               w_chk_next   = r_chk ^ in_data;
               w_state_next = S_WR;
            end
         end
         S_WR: begin
            // The strobe for this cycle is already out; abort only stops what follows.
            if (abort) begin
               w_state_next = S_ERR;
            end else if (w_last) begin
               w_state_next = S_CHK;
            end else begin
               w_adr_next   = r_adr + AdrOne;
               w_state_next = S_HI;
            end
         end
         S_CHK: begin
            if (abort) begin
               w_state_next = S_ERR;
            end else if (w_xfer) begin
               w_state_next = (in_data == r_chk) ? S_DONE : S_ERR;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      w_in_ready_next = (w_state_next == S_HI) || (w_state_next == S_LO) ||
                        (w_state_next == S_CHK);
      w_wr_en_next    = (w_state_next == S_WR);
      w_busy_next     = (w_state_next == S_HI) || (w_state_next == S_LO) ||
                        (w_state_next == S_WR) || (w_state_next == S_CHK);
      w_done_next     = (w_state_next == S_DONE);
      w_err_next      = (w_state_next == S_ERR);
      w_cpu_hold_next = w_busy_next || w_err_next;
   end

   // State, datapath and output registers; reset abandons any load in progress
   // and releases the CPU, leaving memory contents untouched.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         r_state    <= S_IDLE;
         r_len      <= '0;
         r_chk      <= '0;
         r_hi       <= '0;
         r_adr      <= '0;
         r_data     <= '0;
         r_in_ready <= 1'b0;
         r_wr_en    <= 1'b0;
         r_cpu_hold <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_len      <= w_len_next;
         r_chk      <= w_chk_next;
         r_hi       <= w_hi_next;
         r_adr      <= w_adr_next;
         r_data     <= w_data_next;
         r_in_ready <= w_in_ready_next;
         r_wr_en    <= w_wr_en_next;
         r_cpu_hold <= w_cpu_hold_next;
         r_busy     <= w_busy_next;
         r_done     <= w_done_next;
         r_err      <= w_err_next;
      end
   end

   assign in_ready    = r_in_ready;
   assign mem_wr_en   = r_wr_en;
   assign mem_wr_adr  = r_adr;
   assign mem_wr_data = r_data;
   assign cpu_hold    = r_cpu_hold;
   assign busy        = r_busy;
   assign done        = r_done;
   assign err         = r_err;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: drives byte streams with random gaps and
// start noise; a transaction-level model predicts the write sequence and the
// final status from the byte list alone.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        res_n;
   logic        start;
   logic [7:0]  len;
   logic        abort;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        mem_wr_en;
   logic [7:0]  mem_wr_adr;
   logic [15:0] mem_wr_data;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        err;

   int          checks = 0;
   int          errors = 0;

   logic [7:0]  tx_q[$];      // bytes to send: 2n instruction bytes + checksum
   logic [23:0] exp_wr[$];    // expected writes {adr, word}
   logic [15:0] wr_log[$];    // words actually written in the current load
   logic [7:0]  model_chk;
   bit          exp_good;
   int          wr_cnt = 0;
   int          cyc = 0;
   int          last_wr = -10;

   program_loader #(.DataWidth(8), .IRWidth(16), .PC_WIDTH(8)) dut (
      .clk         (clk),
      .res_n       (res_n),
      .start       (start),
      .len         (len),
      .abort       (abort),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_adr  (mem_wr_adr),
      .mem_wr_data (mem_wr_data),
      .cpu_hold    (cpu_hold),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Compare process: every cycle, check writes against the expected sequence
   // and the status outputs against their defining relations.
   always @(negedge clk) begin
      logic [23:0] e;
      cyc++;
      if (res_n) begin
         chk("hold_is_busy_or_err", {31'd0, cpu_hold}, {31'd0, busy | err});
         chk("ready_only_when_busy", {31'd0, in_ready & ~busy}, 32'd0);
         chk("done_err_exclusive", {31'd0, done & err}, 32'd0);
         if (mem_wr_en) begin
            chk("write_spacing_ge3", (cyc - last_wr >= 3) ? 32'd1 : 32'd0, 32'd1);
            chk("write_while_busy", {31'd0, busy}, 32'd1);
            last_wr = cyc;
            wr_cnt++;
            wr_log.push_back(mem_wr_data);
            if (exp_wr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got adr %0h data %0h expected no write",
                        mem_wr_adr, mem_wr_data);
            end else begin
               e = exp_wr.pop_front();
               chk("write_adr", {24'd0, mem_wr_adr}, {24'd0, e[23:16]});
               chk("write_data", {16'd0, mem_wr_data}, {16'd0, e[15:0]});
            end
         end
      end
   end

   // Model: instruction i is {byte 2i, byte 2i+1} at address i; the load is
   // good when the trailing byte equals the XOR of all instruction bytes.
   task automatic derive(input int n);
      logic [7:0] x;
      x = 8'd0;
      exp_wr.delete();
      for (int i = 0; i < n; i++) begin
         exp_wr.push_back({8'(i), tx_q[2*i], tx_q[2*i+1]});
         x = x ^ tx_q[2*i] ^ tx_q[2*i+1];
      end
      model_chk = x;
      exp_good  = (tx_q[2*n] == x);
   endtask

   task automatic build_random(input int n, input bit good);
      logic [7:0] x;
      logic [7:0] b;
      x = 8'd0;
      tx_q.delete();
      for (int i = 0; i < 2*n; i++) begin
         b = 8'($urandom);
         tx_q.push_back(b);
         x = x ^ b;
      end
      tx_q.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
      derive(n);
   endtask

   task automatic load_fixed(input logic [7:0] chk_byte);
      tx_q.delete();
      tx_q.push_back(8'h12);
      tx_q.push_back(8'h34);
      tx_q.push_back(8'h56);
      tx_q.push_back(8'h78);
      tx_q.push_back(chk_byte);
      derive(2);
   endtask

   // Pulse start for one cycle; called at posedge+1.
   task automatic do_start(input logic [7:0] l);
      start = 1'b1;
      len   = l;
      @(posedge clk);
      #1;
      start = 1'b0;
      len   = 8'($urandom);
      wr_cnt = 0;
      wr_log.delete();
      chk("start_busy", {31'd0, busy}, 32'd1);
      chk("start_hold", {31'd0, cpu_hold}, 32'd1);
      chk("start_clears_done", {31'd0, done}, 32'd0);
      chk("start_clears_err", {31'd0, err}, 32'd0);
      chk("start_ready", {31'd0, in_ready}, 32'd1);
   endtask

   // Offer the first nbytes of tx_q with random valid gaps; optionally
   // toggle start and len while the load is running.
   task automatic send_stream(input int gap_pct, input bit noise, input int nbytes);
      int idx;
      int c;
      int budget;
      idx = 0;
      c = 0;
      budget = 40 * nbytes + 200;
      while (idx < nbytes && c < budget) begin
         in_valid = ($urandom_range(99) >= gap_pct);
         in_data  = tx_q[idx];
         if (noise) begin
            start = ($urandom_range(7) == 0);
            len   = 8'($urandom);
         end
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         @(posedge clk);
         #1;
         c++;
      end
      in_valid = 1'b0;
      in_data  = 8'd0;
      start    = 1'b0;
      if (idx < nbytes) begin
         checks++;
         errors++;
         $display("FAIL stream_timeout: got %0d bytes taken expected %0d", idx, nbytes);
      end
   endtask

   task automatic check_end(input int n);
      chk("end_done", {31'd0, done}, {31'd0, exp_good});
      chk("end_err", {31'd0, err}, {31'd0, !exp_good});
      chk("end_hold", {31'd0, cpu_hold}, {31'd0, !exp_good});
      chk("end_busy", {31'd0, busy}, 32'd0);
      chk("end_ready", {31'd0, in_ready}, 32'd0);
      chk("end_write_count", wr_cnt, n);
      chk("end_writes_left", exp_wr.size(), 0);
   endtask

   task automatic run_load(input logic [7:0] l, input int n, input int gap, input bit noise);
      do_start(l);
      send_stream(gap, noise, 2*n + 1);
      check_end(n);
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
   endtask

   task automatic check_all_zero(string tag);
      chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
      chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
      chk({tag, "_adr"}, {24'd0, mem_wr_adr}, 32'd0);
      chk({tag, "_data"}, {16'd0, mem_wr_data}, 32'd0);
   endtask

   initial begin
      int n;
      bit g;
      res_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'd0;
      len      = 8'd0;
      #12;
      check_all_zero("reset");
      @(posedge clk);
      #1;
      res_n = 1'b1;

      // Basic two-instruction load with a good checksum.
      load_fixed(8'h08);
      chk("model_xor_literal", {24'd0, model_chk}, 32'h08);
      chk("model_good_literal", {31'd0, exp_good}, 32'd1);
      run_load(8'd2, 2, 0, 1'b0);
      chk("t2_nwrites", wr_log.size(), 2);
      chk("t2_word0", {16'd0, wr_log[0]}, 32'h1234);
      chk("t2_word1", {16'd0, wr_log[1]}, 32'h5678);
      $display("load len=2 good: done=%0d err=%0d hold=%0d", done, err, cpu_hold);

      // Same stream with a bad checksum, then a new start clears err.
      load_fixed(8'h09);
      chk("model_bad_literal", {31'd0, exp_good}, 32'd0);
      run_load(8'd2, 2, 0, 1'b0);
      chk("t3_err_literal", {31'd0, err}, 32'd1);
      exp_wr.delete();
      do_start(8'd2);
      pulse_abort();
      chk("t3_abort_err", {31'd0, err}, 32'd1);
      $display("load len=2 bad checksum: err=%0d hold=%0d", err, cpu_hold);

      // Asynchronous reset in the middle of HI.
      do_start(8'd2);
      #3;
      res_n = 1'b0;
      #1;
      check_all_zero("midload_reset");
      @(posedge clk);
      #1;
      res_n = 1'b1;
      chk("after_reset_idle", {31'd0, busy}, 32'd0);
      $display("reset mid-HI: busy=%0d hold=%0d", busy, cpu_hold);

      // Gapped stream with start/len noise must give the same writes.
      load_fixed(8'h08);
      run_load(8'd2, 2, 40, 1'b1);
      chk("t4_word0", {16'd0, wr_log[0]}, 32'h1234);
      chk("t4_word1", {16'd0, wr_log[1]}, 32'h5678);
      $display("load len=2 gapped+noise: writes=%0d done=%0d", wr_cnt, done);

      // Full 256-instruction load via len=0.
      build_random(256, 1'b1);
      run_load(8'd0, 256, 0, 1'b0);
      chk("t5_nwrites", wr_log.size(), 256);
      chk("t5_adr_holds_ff", {24'd0, mem_wr_adr}, 32'hFF);
      $display("load len=0: writes=%0d last_adr=%0h done=%0d", wr_cnt, mem_wr_adr, done);

      // Abort in DONE is ignored.
      pulse_abort();
      chk("abort_in_done_done", {31'd0, done}, 32'd1);
      chk("abort_in_done_err", {31'd0, err}, 32'd0);
      chk("abort_in_done_hold", {31'd0, cpu_hold}, 32'd0);

      // Abort during LO: ERR next cycle, no write.
      tx_q.delete();
      tx_q.push_back(8'h12);
      exp_wr.delete();
      do_start(8'd2);
      send_stream(0, 1'b0, 1);
      pulse_abort();
      chk("abort_lo_err", {31'd0, err}, 32'd1);
      chk("abort_lo_busy", {31'd0, busy}, 32'd0);
      chk("abort_lo_ready", {31'd0, in_ready}, 32'd0);
      chk("abort_lo_hold", {31'd0, cpu_hold}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_lo_no_write", wr_cnt, 0);
      $display("abort in LO: err=%0d writes=%0d", err, wr_cnt);

      // Abort coinciding with WR: that write still lands, nothing after it.
      load_fixed(8'h08);
      do_start(8'd2);
      send_stream(0, 1'b0, 2);
      pulse_abort();
      repeat (3) @(posedge clk);
      #1;
      chk("abort_wr_err", {31'd0, err}, 32'd1);
      chk("abort_wr_one_write", wr_cnt, 1);
      chk("abort_wr_remaining", exp_wr.size(), 1);
      exp_wr.delete();
      $display("abort in WR: err=%0d writes=%0d", err, wr_cnt);

      // From IDLE: abort alone ignored; start+abort together starts.
      res_n = 1'b0;
      #2;
      res_n = 1'b1;
      @(posedge clk);
      #1;
      pulse_abort();
      chk("abort_idle_err", {31'd0, err}, 32'd0);
      chk("abort_idle_busy", {31'd0, busy}, 32'd0);
      start = 1'b1;
      len   = 8'd1;
      pulse_abort();
      start = 1'b0;
      chk("start_abort_busy", {31'd0, busy}, 32'd1);
      chk("start_abort_err", {31'd0, err}, 32'd0);
      pulse_abort();
      $display("start+abort in IDLE: started then aborted err=%0d", err);

      // Randomized loads chained from whatever state the previous one left.
      for (int k = 0; k < 8; k++) begin
         n = $urandom_range(1, 6);
         g = ($urandom_range(1) == 1);
         build_random(n, g);
         run_load(8'(n), n, $urandom_range(0, 60), 1'b1);
         $display("random load n=%0d good=%0d: writes=%0d done=%0d err=%0d",
                  n, g, wr_cnt, done, err);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
